// File: rtl/handshake_sram_pipe_pkg.sv
// Shared definitions for the handshake SRAM model: size encodings, byte-count helper
// and the response record layout.
package ncpu32k_tb_sram_pkg;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd3;
    localparam logic [2:0] SIZE_D = 3'd4;

    localparam int RSP_IW_MAX = 8;
    localparam int RSP_DW_MAX = 64;

    typedef struct packed {
        logic [RSP_IW_MAX-1:0] id;
        logic                  we;
        logic [RSP_DW_MAX-1:0] rdata;
        logic                  err;
    } rsp_t;

    // Zero marks an encoding that is never legal.
    function automatic logic [3:0] size_nbytes(input logic [2:0] size);
        case (size)
            SIZE_B:  return 4'd1;
            SIZE_H:  return 4'd2;
            SIZE_W:  return 4'd4;
            SIZE_D:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/handshake_sram_pipe_rsp_fifo.sv
// Synchronous response FIFO; the head is presented directly and reads as zero when empty.
module tb_sram_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [W-1:0]   r_mem [DEPTH];
    logic [PTW-1:0] r_wr;
    logic [PTW-1:0] r_rd;
    logic [CW-1:0]  r_count;
    logic           w_pop;

    function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
        return (p == PTW'(DEPTH - 1)) ? '0 : p + PTW'(1);
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = (r_count == '0) ? '0 : r_mem[r_rd];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/handshake_sram_pipe.sv
// Byte-addressed SRAM model with pipelined, tagged valid/ready responses for CPU benches.
// Optional NCPU_TB_SRAM_STALL_EN: an LFSR randomly withholds req_ready.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module handshake_sram_pipe
    import ncpu32k_tb_sram_pkg::*;
#(
    parameter int    DW         = 32,
    parameter int    AW         = `NCPU_AW,
    parameter int    IW         = 4,
    parameter int    SIZE_BYTES = 32768,
    parameter string MEMH_FILE  = "",
    parameter int    LATENCY    = 2,
    parameter int    DEPTH      = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic [IW-1:0] req_id,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [IW-1:0] rsp_id,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    localparam int NB  = DW / 8;
    localparam int MAW = $clog2(SIZE_BYTES);
    localparam int PW  = IW + 1 + DW + 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int EW  = AW + 4;

    logic [7:0]         r_mem [SIZE_BYTES];
    logic [LATENCY-1:0] r_pv;
    logic [PW-1:0]      r_pd [LATENCY];
    logic [CW-1:0]      r_inflight;
    logic               r_req_ready;

    logic               w_accept;
    logic               w_pop;
    logic               w_err;
    logic               w_stall;
    logic [3:0]         w_nbytes;
    logic [EW-1:0]      w_end;
    logic [MAW-1:0]     w_idx;
    logic [DW-1:0]      w_rdata;
    logic [PW-1:0]      w_head;
    logic [CW-1:0]      w_fifo_cnt;
    logic [CW-1:0]      w_inflight_nxt;

    assign w_accept  = req_valid && r_req_ready;
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_idx     = req_addr[MAW-1:0];
    assign req_ready = r_req_ready;
    assign rsp_valid = (w_fifo_cnt != '0);
    assign rsp_id    = w_head[PW-1 -: IW];
    assign rsp_we    = w_head[DW+1];
    assign rsp_rdata = w_head[DW:1];
    assign rsp_err   = w_head[0];

    // Decode size/range (end address widened so it cannot wrap) and fetch read bytes.
    always_comb begin
        w_nbytes = size_nbytes(req_size);
        w_end    = {4'b0000, req_addr} + EW'(w_nbytes);
        w_err    = (w_nbytes == 4'd0) || (w_nbytes > 4'(NB)) || (w_end > EW'(SIZE_BYTES));
        w_rdata  = '0;
        for (int i = 0; i < NB; i++) begin
            if (!req_we && !w_err && (4'(i) < w_nbytes)) begin
                w_rdata[i*8 +: 8] = r_mem[w_idx + MAW'(i)];
            end else begin
                w_rdata[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Memory array; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < w_nbytes) r_mem[w_idx + MAW'(i)] <= req_wdata[i*8 +: 8];
            end
        end
    end

    // Fixed-latency response pipeline; never stalls because occupancy is capped at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < LATENCY; i++) r_pd[i] <= '0;
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= {req_id, req_we, w_rdata, w_err};
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    tb_sram_rsp_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (r_pv[LATENCY-1]),
        .i_data  (r_pd[LATENCY-1]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

    // Outstanding count covers both pipeline stages and FIFO entries.
    always_comb begin
        case ({w_accept, w_pop})
            2'b10:   w_inflight_nxt = r_inflight + CW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

`ifdef NCPU_TB_SRAM_STALL_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_stall    = (w_lfsr_nxt[1:0] == 2'b00);

    // Free-running stall pattern generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= 16'hACE1;
        else        r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_stall = 1'b0;
`endif

    // Registered ready: a pop only frees a slot from the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_inflight  <= w_inflight_nxt;
            r_req_ready <= (w_inflight_nxt < CW'(DEPTH)) && !w_stall;
        end
    end

endmodule

// File: tb/tb_handshake_sram_pipe.sv
// Self-checking bench for handshake_sram_pipe: directed scenarios plus randomized traffic
// checked against a byte-array memory model and an in-order expected-response queue.
module tb_handshake_sram_pipe;
    import ncpu32k_tb_sram_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int SZ    = 32768;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [IW-1:0] req_id;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IW-1:0] rsp_id;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    handshake_sram_pipe #(
        .DW(DW), .AW(AW), .IW(IW), .SIZE_BYTES(SZ), .LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_id(req_id), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] mm [SZ];
    rsp_t       exp_q [$];
    int         acc_q [$];
    int         cyc = 0;
    int         stall_seen = 0;
    bit         ready_known = 1'b0;
    bit         held = 1'b0;
    bit         front_seen = 1'b0;
    bit         exact = 1'b0;
    bit         rand_rdy = 1'b0;
    logic [IW-1:0] next_id = '0;
    logic [IW-1:0] h_id;
    logic          h_we;
    logic          h_err;
    logic [DW-1:0] h_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one accepted request: ordering by acceptance, immediate writes.
    task automatic model_accept();
        rsp_t            r;
        int              nb;
        longint unsigned last;
        r    = '0;
        r.id = RSP_IW_MAX'(req_id);
        r.we = req_we;
        nb   = (req_size >= 3'd1 && req_size <= 3'd3) ? (1 << (req_size - 3'd1)) : 0;
        last = {32'b0, req_addr} + 64'(nb);
        r.err = (nb == 0) || (last > 64'(SZ));
        if (!r.err) begin
            for (int i = 0; i < nb; i++) begin
                if (req_we) mm[int'(req_addr) + i] = req_wdata[i*8 +: 8];
                else        r.rdata[i*8 +: 8] = mm[int'(req_addr) + i];
            end
        end
        exp_q.push_back(r);
        acc_q.push_back(cyc);
    endtask

    // One clock: sample outputs, score responses, record an accept, then advance.
    task automatic step(output bit acc);
        bit pop;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        if (ready_known) begin
`ifdef NCPU_TB_SRAM_STALL_EN
            if (req_ready) check("ready_cap", 64'(exp_q.size() < DEPTH), 64'd1);
            else if (exp_q.size() < DEPTH) stall_seen++;
`else
            check("req_ready", 64'(req_ready), 64'(exp_q.size() < DEPTH));
`endif
        end
        if (held) begin
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_id", 64'(rsp_id), 64'(h_id));
            check("hold_we", 64'(rsp_we), 64'(h_we));
            check("hold_rdata", 64'(rsp_rdata), 64'(h_rdata));
            check("hold_err", 64'(rsp_err), 64'(h_err));
        end
        if (rsp_valid && exp_q.size() == 0) begin
            check("spurious_rsp", 64'(rsp_valid), 64'd0);
        end else if (rsp_valid) begin
            if (!front_seen) begin
                front_seen = 1'b1;
                if (exact) check("latency", 64'(cyc - 1 - acc_q[0]), 64'(LAT));
                else       check("latency_min", 64'((cyc - 1 - acc_q[0]) >= LAT), 64'd1);
            end
            if (pop) begin
                check("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                check("rsp_we", 64'(rsp_we), 64'(exp_q[0].we));
                check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
                check("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                front_seen = 1'b0;
            end
        end
        held    = rsp_valid && !rsp_ready;
        h_id    = rsp_id;
        h_we    = rsp_we;
        h_rdata = rsp_rdata;
        h_err   = rsp_err;
        if (acc) model_accept();
        @(posedge clk);
        cyc++;
        #1;
        ready_known = 1'b1;
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wd);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_id    = next_id;
        req_wdata = wd;
        for (int t = 0; t < 200 && !acc; t++) step(acc);
        check("accept_timeout", 64'(acc), 64'd1);
        next_id++;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int t = 0; t < n; t++) step(acc);
    endtask

    task automatic drain();
        bit acc;
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) step(acc);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bit          acc;
        int          n_acc;
        int          k;
        logic [2:0]  sz;
        logic [31:0] a;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 3'd0; req_id = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_rsp_we", 64'(rsp_we), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;

        // Known contents for the regions read later.
        do_req(1'b1, 32'h104, SIZE_W, 32'h0000_0000);
        do_req(1'b1, 32'(SZ - 4), SIZE_W, 32'h1122_3344);
        do_req(1'b1, 32'(SZ - 8), SIZE_W, 32'h5566_7788);
        drain();

        // Write then immediately read back, exact latency.
        exact = 1'b1;
        do_req(1'b1, 32'h100, SIZE_W, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h100, SIZE_W, 32'h0);
        drain();

        // Eight back-to-back byte reads.
        for (int i = 0; i < 8; i++) do_req(1'b0, 32'h100 + 32'(i), SIZE_B, 32'h0);
        drain();
        exact = 1'b0;

        // Backpressure fills exactly DEPTH slots.
        rsp_ready = 1'b0; n_acc = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_addr = 32'h100;
        for (int t = 0; t < 30; t++) begin
            req_id = next_id;
            step(acc);
            if (acc) begin n_acc++; next_id++; end
        end
        check("bp_accepts", 64'(n_acc), 64'(DEPTH));
        check("bp_full_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        step(acc);
`ifndef NCPU_TB_SRAM_STALL_EN
        check("ready_after_pop", 64'(req_ready), 64'd1);
`endif
        drain();

        // Error responses and the untouched top-of-memory bytes.
        do_req(1'b0, 32'h0, 3'd0, 32'h0);
        do_req(1'b0, 32'(SZ - 2), SIZE_W, 32'h0);
        do_req(1'b0, 32'(SZ - 2), SIZE_B, 32'h0);
        do_req(1'b0, 32'hFFFF_FFFE, SIZE_W, 32'h0);
        do_req(1'b1, 32'(SZ - 1), SIZE_H, 32'hFFFF_FFFF);
        do_req(1'b0, 32'h100, 3'd4, 32'h0);
        do_req(1'b0, 32'(SZ - 4), SIZE_W, 32'h0);
        drain();

        // Reset with responses outstanding.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_req(1'b0, 32'h100, SIZE_W, 32'h0);
        idle(3);
        check("pre_reset_valid", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(rsp_valid), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd0);
        check("async_rst_id", 64'(rsp_id), 64'd0);
        exp_q.delete(); acc_q.delete();
        held = 1'b0; front_seen = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1; ready_known = 1'b0; rsp_ready = 1'b1;
        idle(6);
        do_req(1'b0, 32'h100, SIZE_W, 32'h0);
        drain();

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'h200 + 32'(4 * i), SIZE_W, $urandom);
        drain();
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                sz = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(4, 7));
                do_req(1'($urandom_range(0, 1)), 32'h200 + $urandom_range(0, 60), sz, $urandom);
            end else if (k == 1) begin
                a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                                : 32'(SZ) - $urandom_range(0, 3);
                do_req(1'($urandom_range(0, 1)), a, SIZE_W, $urandom);
            end else if (k == 2) begin
                do_req(1'b0, 32'(SZ - 8) + $urandom_range(0, 4), SIZE_W, 32'h0);
            end else begin
                do_req(1'($urandom_range(0, 1)), 32'h200 + $urandom_range(0, 60),
                       3'($urandom_range(1, 3)), $urandom);
            end
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();
        idle(4);
`ifdef NCPU_TB_SRAM_STALL_EN
        check("stall_seen", 64'(stall_seen > 0), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
